// File: rtl/rob_nport.sv
// Reorder buffer: in-order allocation, out-of-order completion on N_WB writeback ports,
// and one in-order retirement per cycle to the register file or dCache with precise exceptions.
module rob_nport #(
  parameter int unsigned ARCH_BITS    = 32,
  parameter int unsigned REG_IDX_BITS = 5,
  parameter int unsigned ROB_SLOTS    = 16,
  parameter int unsigned ROB_IDX_BITS = 4,
  parameter int unsigned N_WB         = 5
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clear,
  input  logic                           alloc_req,
  output logic                           alloc_ready,
  output logic [ROB_IDX_BITS-1:0]        alloc_idx,
  output logic [ROB_IDX_BITS:0]          count,
  input  logic [N_WB-1:0]                wb_valid,
  input  logic [N_WB*ROB_IDX_BITS-1:0]   wb_idx,
  input  logic [N_WB-1:0]                wb_except,
  input  logic [N_WB*ARCH_BITS-1:0]      wb_pc,
  input  logic [N_WB*ARCH_BITS-1:0]      wb_addr,
  input  logic [N_WB*ARCH_BITS-1:0]      wb_data,
  input  logic [N_WB*REG_IDX_BITS-1:0]   wb_dst,
  input  logic [N_WB-1:0]                wb_we,
  input  logic                           wb_we_mem,
  input  logic                           wb_byte_mem,
  output logic                           except,
  output logic [ARCH_BITS-1:0]           except_pc,
  output logic [ARCH_BITS-1:0]           except_addr,
  output logic [N_WB-1:0]                except_type,
  output logic                           w_en_reg,
  output logic [REG_IDX_BITS-1:0]        w_dst_reg,
  output logic [ARCH_BITS-1:0]           w_data_reg,
  output logic                           w_en_mem,
  output logic                           w_byte_mem,
  output logic [ARCH_BITS-1:0]           w_addr_mem,
  output logic [ARCH_BITS-1:0]           w_data_mem,
  input  logic                           mem_ready
);

  localparam int unsigned CNT_BITS = ROB_IDX_BITS + 1;
  localparam int unsigned MEM_PORT = N_WB - 1;

  logic [ROB_IDX_BITS-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_BITS-1:0]     count_q, count_d;
  logic [ROB_SLOTS-1:0]    alloc_q, alloc_d, done_q, done_d;

  logic [ARCH_BITS-1:0]    pc_q     [ROB_SLOTS];
  logic [ARCH_BITS-1:0]    addr_q   [ROB_SLOTS];
  logic [ARCH_BITS-1:0]    data_q   [ROB_SLOTS];
  logic [REG_IDX_BITS-1:0] dst_q    [ROB_SLOTS];
  logic [N_WB-1:0]         etype_q  [ROB_SLOTS];
  logic                    we_q     [ROB_SLOTS];
  logic                    exc_q    [ROB_SLOTS];
  logic                    we_mem_q [ROB_SLOTS];
  logic                    byte_q   [ROB_SLOTS];

  logic [ROB_IDX_BITS-1:0] wb_slot [N_WB];
  logic [N_WB-1:0]         wb_ok;
  logic head_valid, head_exc, head_st, retire, flush, alloc_fire;

  // Writebacks land only on allocated, not-yet-completed slots.
  always_comb begin
    for (int k = 0; k < int'(N_WB); k++) begin
      wb_slot[k] = wb_idx[k*ROB_IDX_BITS +: ROB_IDX_BITS];
      wb_ok[k]   = wb_valid[k] && alloc_q[wb_slot[k]] && !done_q[wb_slot[k]];
    end
  end

  assign head_valid = alloc_q[head_q] && done_q[head_q];
  assign head_exc   = head_valid && exc_q[head_q];
  assign head_st    = head_valid && !exc_q[head_q] && we_mem_q[head_q];
  assign retire     = head_valid && (exc_q[head_q] || !we_mem_q[head_q] || mem_ready);
  assign flush      = clear || head_exc;
  assign alloc_fire = alloc_req && alloc_ready;

  assign alloc_ready = (count_q != CNT_BITS'(ROB_SLOTS));
  assign alloc_idx   = tail_q;
  assign count       = count_q;

  assign except      = head_exc;
  assign except_pc   = head_exc ? pc_q[head_q]    : '0;
  assign except_addr = head_exc ? addr_q[head_q]  : '0;
  assign except_type = head_exc ? etype_q[head_q] : '0;

  assign w_en_reg   = head_valid && !exc_q[head_q] && !we_mem_q[head_q] && we_q[head_q];
  assign w_dst_reg  = w_en_reg ? dst_q[head_q]  : '0;
  assign w_data_reg = w_en_reg ? data_q[head_q] : '0;
  assign w_en_mem   = head_st;
  assign w_byte_mem = head_st && byte_q[head_q];
  assign w_addr_mem = head_st ? addr_q[head_q] : '0;
  assign w_data_mem = head_st ? data_q[head_q] : '0;

  // Pointer/status next state; flush overrides everything in the same cycle.
  always_comb begin
    alloc_d = alloc_q;
    done_d  = done_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CNT_BITS'(alloc_fire) - CNT_BITS'(retire);
    for (int k = 0; k < int'(N_WB); k++) begin
      if (wb_ok[k]) done_d[wb_slot[k]] = 1'b1;
    end
    if (retire) begin
      alloc_d[head_q] = 1'b0;
      done_d[head_q]  = 1'b0;
      head_d          = head_q + ROB_IDX_BITS'(1);
    end
    if (alloc_fire) begin
      alloc_d[tail_q] = 1'b1;
      done_d[tail_q]  = 1'b0;
      tail_d          = tail_q + ROB_IDX_BITS'(1);
    end
    if (flush) begin
      alloc_d = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      alloc_q <= '0;
      done_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      alloc_q <= alloc_d;
      done_q  <= done_d;
    end
  end

  // Payload capture; descending loop lets the lowest port win a shared index.
  always_ff @(posedge clk) begin
    for (int k = int'(N_WB) - 1; k >= 0; k--) begin
      if (wb_ok[k]) begin
        pc_q[wb_slot[k]]     <= wb_pc[k*ARCH_BITS +: ARCH_BITS];
        addr_q[wb_slot[k]]   <= wb_addr[k*ARCH_BITS +: ARCH_BITS];
        data_q[wb_slot[k]]   <= wb_data[k*ARCH_BITS +: ARCH_BITS];
        dst_q[wb_slot[k]]    <= wb_dst[k*REG_IDX_BITS +: REG_IDX_BITS];
        we_q[wb_slot[k]]     <= wb_we[k];
        exc_q[wb_slot[k]]    <= wb_except[k];
        etype_q[wb_slot[k]]  <= N_WB'(1) << k;
        we_mem_q[wb_slot[k]] <= (k == int'(MEM_PORT)) ? wb_we_mem : 1'b0;
        byte_q[wb_slot[k]]   <= (k == int'(MEM_PORT)) ? wb_byte_mem : 1'b0;
      end
    end
  end

endmodule
